// File: rtl/packet_buffer_read_controller.sv
// Round-robin drain of the per-lane packet FIFOs into one AXI-Stream, one whole packet per grant.
// Define PACKET_BUFFER_READ_LEN_CHECK_EN to flag and clamp zero/oversize header lengths on err_o.
module packet_buffer_read_controller #(
   parameter int NUM_LANES         = 4,
   parameter int AXI_WIDTH         = 64,
   parameter int MAX_PACKET_LENGTH = 1600
) (
   input  logic                                clk_i,
   input  logic                                rst_i,
   input  logic [NUM_LANES-1:0][AXI_WIDTH-1:0] lane_data_i,
   input  logic [NUM_LANES-1:0]                lane_valid_i,
   output logic [NUM_LANES-1:0]                lane_ready_o,
   output logic [AXI_WIDTH-1:0]                m_data_o,
   output logic [AXI_WIDTH/8-1:0]              m_keep_o,
   output logic                                m_valid_o,
   output logic                                m_last_o,
   input  logic                                m_ready_i,
   output logic                                err_o
);

   localparam int BYTES  = AXI_WIDTH / 8;
   localparam int LANE_W = $clog2(NUM_LANES);
   localparam int REM_W  = $clog2(MAX_PACKET_LENGTH / BYTES) + 1;
   localparam int TAIL_W = $clog2(BYTES);
   localparam int LEN_W  = 16;

   // Only the length is interpreted here; the header sits in the low bits of the first beat.
   typedef struct packed {
      logic [LEN_W-1:0] packet_length;
   } packet_header_t;

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_STREAM = 1'b1;

   logic [0:0]        state_r;
   logic [LANE_W-1:0] grant_r;
   logic [LANE_W-1:0] last_r;
   logic [REM_W-1:0]  rem_r;
   logic [TAIL_W-1:0] tail_r;
   logic              first_r;

   logic                              streaming;
   logic                              hs;
   logic                              is_last;
   logic [NUM_LANES-1:0][LANE_W-1:0]  cand_lane;
   logic [NUM_LANES-1:0]              cand_valid;
   logic [LANE_W-1:0]                 arb_lane;
   logic                              arb_found;
   packet_header_t                    hdr;
   logic [LEN_W-1:0]                  len_eff;
   logic [LEN_W:0]                    beats;
   logic [TAIL_W-1:0]                 hdr_tail;
   logic [TAIL_W-1:0]                 keep_tail;
   logic [BYTES-1:0]                  tail_mask;

   // Candidate k is the lane k+1 positions after the last served lane, wrapping modulo NUM_LANES.
   for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_cand
      logic [LANE_W:0] rot_sum;
      assign rot_sum = {1'b0, last_r} + (LANE_W+1)'(gi + 1);
      assign cand_lane[gi] = (rot_sum >= (LANE_W+1)'(NUM_LANES))
                             ? LANE_W'(rot_sum - (LANE_W+1)'(NUM_LANES))
                             : rot_sum[LANE_W-1:0];
      assign cand_valid[gi] = lane_valid_i[cand_lane[gi]];
   end

   always_comb begin
      arb_found = 1'b0;
      arb_lane  = '0;
      for (int k = NUM_LANES - 1; k >= 0; k--) begin
         if (cand_valid[k]) begin
            arb_found = 1'b1;
            arb_lane  = cand_lane[k];
         end
      end
   end

   assign hdr = lane_data_i[grant_r][$bits(packet_header_t)-1:0];

`ifdef PACKET_BUFFER_READ_LEN_CHECK_EN
   logic len_bad;
   logic err_r;

   assign len_bad = (hdr.packet_length == '0) ||
                    (hdr.packet_length > LEN_W'(MAX_PACKET_LENGTH));
   assign len_eff = (hdr.packet_length > LEN_W'(MAX_PACKET_LENGTH))
                    ? LEN_W'(MAX_PACKET_LENGTH) : hdr.packet_length;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         err_r <= 1'b0;
      end else if (hs && first_r && len_bad) begin
         err_r <= 1'b1;
      end
   end

   assign err_o = err_r;
`else
   assign len_eff = hdr.packet_length;
   assign err_o   = 1'b0;
`endif

   // A zero length still occupies one beat (the header itself).
   assign beats = (len_eff == '0) ? (LEN_W+1)'(1)
                  : ((LEN_W+1)'(len_eff) + (LEN_W+1)'(BYTES - 1)) / (LEN_W+1)'(BYTES);
   assign hdr_tail = TAIL_W'(len_eff % LEN_W'(BYTES));

   assign streaming = (state_r == ST_STREAM);
   assign is_last   = first_r ? (beats == (LEN_W+1)'(1)) : (rem_r == REM_W'(1));
   assign keep_tail = first_r ? hdr_tail : tail_r;

   for (genvar gi = 0; gi < BYTES; gi++) begin : g_keep
      assign tail_mask[gi] = (keep_tail == '0) || (32'(keep_tail) > gi);
   end

   for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_ready
      assign lane_ready_o[gi] = streaming && m_ready_i && (grant_r == LANE_W'(gi));
   end

   assign m_valid_o = streaming && lane_valid_i[grant_r];
   assign m_data_o  = lane_data_i[grant_r];
   assign m_last_o  = m_valid_o && is_last;
   assign m_keep_o  = !m_valid_o ? '0 : (is_last ? tail_mask : '1);
   assign hs        = m_valid_o && m_ready_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_r <= ST_IDLE;
         grant_r <= '0;
         last_r  <= LANE_W'(NUM_LANES - 1);
         rem_r   <= '0;
         tail_r  <= '0;
         first_r <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (arb_found) begin
                  grant_r <= arb_lane;
                  first_r <= 1'b1;
                  state_r <= ST_STREAM;
               end
            end
            default: begin
               // Everything holds while the granted lane or the sink stalls.
               if (hs) begin
                  first_r <= 1'b0;
                  if (first_r) begin
                     rem_r  <= REM_W'(beats - (LEN_W+1)'(1));
                     tail_r <= hdr_tail;
                  end else begin
                     rem_r <= rem_r - REM_W'(1);
                  end
                  if (is_last) begin
                     last_r  <= grant_r;
                     state_r <= ST_IDLE;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_packet_buffer_read_controller.sv
// Bench for packet_buffer_read_controller: lane FIFO models, a round-robin packet-list reference,
// a table of single-packet vectors and directed corner-case sequences.
module tb_packet_buffer_read_controller;

   localparam int NL   = 4;
   localparam int W    = 64;
   localparam int BY   = 8;
   localparam int MAXL = 1600;

   logic                 clk_i = 1'b0;
   logic                 rst_i = 1'b0;
   logic [NL-1:0][W-1:0] lane_data_i;
   logic [NL-1:0]        lane_valid_i;
   logic [NL-1:0]        lane_ready_o;
   logic [W-1:0]         m_data_o;
   logic [BY-1:0]        m_keep_o;
   logic                 m_valid_o;
   logic                 m_last_o;
   logic                 m_ready_i;
   logic                 err_o;

   packet_buffer_read_controller #(
      .NUM_LANES(NL), .AXI_WIDTH(W), .MAX_PACKET_LENGTH(MAXL)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .lane_data_i(lane_data_i), .lane_valid_i(lane_valid_i), .lane_ready_o(lane_ready_o),
      .m_data_o(m_data_o), .m_keep_o(m_keep_o), .m_valid_o(m_valid_o), .m_last_o(m_last_o),
      .m_ready_i(m_ready_i), .err_o(err_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct { logic [W-1:0] data; bit first; } beat_t;
   typedef struct { int lane; logic [W-1:0] data; bit first; bit last; logic [BY-1:0] keep; int len; } exp_t;
   typedef struct { int lane; int len; int beats; logic [BY-1:0] keep; } vec_t;

   beat_t         lq[NL][$];
   logic [NL-1:0] hold_mask = '0;
   logic [NL-1:0] stall_now = '0;
   int            errors = 0;
   int            checks = 0;
   int            last_lane = NL - 1;
   bit            err_model = 1'b0;
   int            grant_log[$];

   logic          s_valid, s_last, s_mready, s_err;
   logic [BY-1:0] s_keep;
   logic [W-1:0]  s_data;
   logic [NL-1:0] s_lready, s_lvalid;

   function automatic int clamp_len(input int len);
`ifdef PACKET_BUFFER_READ_LEN_CHECK_EN
      if (len > MAXL) return MAXL;
`endif
      return len;
   endfunction

   function automatic int exp_beats(input int len);
      int l = clamp_len(len);
      if (l == 0) return 1;
      return (l + BY - 1) / BY;
   endfunction

   function automatic logic [BY-1:0] exp_keep(input int len);
      int t = clamp_len(len) % BY;
      if (t == 0) return '1;
      return BY'((1 << t) - 1);
   endfunction

   function automatic bit len_bad(input int len);
`ifdef PACKET_BUFFER_READ_LEN_CHECK_EN
      return (len == 0) || (len > MAXL);
`else
      return (len < 0);
`endif
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_pkt(input int lane, input int len);
      beat_t b;
      int n = exp_beats(len);
      for (int j = 0; j < n; j++) begin
         b.data  = {$urandom, $urandom};
         b.first = (j == 0);
         if (j == 0) b.data[15:0] = 16'(len);
         lq[lane].push_back(b);
      end
   endtask

   task automatic apply();
      for (int l = 0; l < NL; l++) begin
         if (lq[l].size() > 0 && !hold_mask[l] && !(stall_now[l] && !lq[l][0].first)) begin
            lane_valid_i[l] = 1'b1;
            lane_data_i[l]  = lq[l][0].data;
         end else begin
            lane_valid_i[l] = 1'b0;
            lane_data_i[l]  = '0;
         end
      end
   endtask

   // Sample at the falling edge, then let the FIFO models pop on the rising edge.
   task automatic cycle();
      @(negedge clk_i);
      s_valid  = m_valid_o;
      s_last   = m_last_o;
      s_keep   = m_keep_o;
      s_data   = m_data_o;
      s_lready = lane_ready_o;
      s_lvalid = lane_valid_i;
      s_mready = m_ready_i;
      s_err    = err_o;
      @(posedge clk_i);
      #1;
      for (int l = 0; l < NL; l++)
         if (s_lready[l] && s_lvalid[l]) void'(lq[l].pop_front());
      apply();
   endtask

   task automatic drain(input int ready_mode, input bit stall_en, input int hold_lane, input int hold_idx,
                        output int hs, output int stalls, output logic [BY-1:0] lkeep);
      exp_t expq[$];
      exp_t e;
      int   pos[NL];
      int   cur, found, len, n, idx, hold_cnt, lane, cand;
      bit   arb, hold_started, done;
      hs = 0; stalls = 0; lkeep = '0; idx = 0; arb = 1'b1;
      hold_cnt = 0; hold_started = 1'b0; done = 1'b0; cur = last_lane;
      for (int l = 0; l < NL; l++) pos[l] = 0;
      // Expected output: whole packets, lanes visited cyclically after the last one served.
      while (1) begin
         found = -1;
         for (int k = 1; k <= NL; k++) begin
            cand = (cur + k) % NL;
            if (found < 0 && pos[cand] < lq[cand].size()) found = cand;
         end
         if (found < 0) break;
         len = int'(lq[found][pos[found]].data[15:0]);
         n   = exp_beats(len);
         for (int j = 0; j < n; j++) begin
            e.lane  = found;
            e.data  = lq[found][pos[found] + j].data;
            e.first = (j == 0);
            e.last  = (j == n - 1);
            e.keep  = (j == n - 1) ? exp_keep(len) : '1;
            e.len   = len;
            expq.push_back(e);
         end
         pos[found] += n;
         cur = found;
      end

      for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
         m_ready_i = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? 1'($urandom_range(0, 1)) : 1'(cyc % 2);
         stall_now = stall_en ? NL'($urandom) : '0;
         if (hold_lane >= 0 && !hold_started && !arb && idx == hold_idx) begin
            hold_cnt = 3;
            hold_started = 1'b1;
         end
         hold_mask = (hold_cnt > 0) ? NL'(1 << hold_lane) : '0;
         apply();
         cycle();
         if (hold_cnt > 0) hold_cnt--;
         chk("err_o", s_err, err_model);
         if (arb) begin
            chk("idle_valid", s_valid, 0);
            chk("idle_lane_ready", s_lready, 0);
            chk("idle_last", s_last, 0);
            chk("idle_keep", s_keep, 0);
            if (idx < expq.size()) arb = 1'b0;
            else done = 1'b1;
         end else begin
            lane = expq[idx].lane;
            chk("lane_ready", s_lready, s_mready ? (1 << lane) : 0);
            chk("m_valid", s_valid, s_lvalid[lane]);
            if (!s_valid) begin
               stalls++;
               chk("stall_last", s_last, 0);
               chk("stall_keep", s_keep, 0);
            end else if (s_mready) begin
               e = expq[idx];
               chk("m_data", s_data, e.data);
               chk("m_last", s_last, e.last);
               chk("m_keep", s_keep, e.keep);
               hs++;
               if (e.first) begin
                  grant_log.push_back(lane);
                  if (len_bad(e.len)) err_model = 1'b1;
               end
               if (e.last) begin
                  lkeep     = s_keep;
                  last_lane = lane;
                  arb       = 1'b1;
                  $display("pkt lane=%0d len=%0d keep=%0h", lane, e.len, s_keep);
               end
               idx++;
            end
         end
      end
      if (!done) chk("drain_timeout", idx, expq.size());
      hold_mask = '0;
      stall_now = '0;
   endtask

   initial begin
      vec_t          vecs[8];
      int            rr_exp[6];
      int            hs, stalls, len_beats_exp;
      logic [BY-1:0] lk;
      logic          err_exp;

      vecs[0] = '{0, 20, 3, 8'h0F};
      vecs[1] = '{1,  8, 1, 8'hFF};
      vecs[2] = '{2,  1, 1, 8'h01};
      vecs[3] = '{3,  0, 1, 8'hFF};
      vecs[4] = '{0,  9, 2, 8'h01};
      vecs[5] = '{1, 16, 2, 8'hFF};
      vecs[6] = '{2, 63, 8, 8'h7F};
      vecs[7] = '{3, 15, 2, 8'h7F};
      rr_exp  = '{0, 1, 3, 0, 1, 3};

      m_ready_i    = 1'b0;
      lane_valid_i = '0;
      lane_data_i  = '0;
      #1 rst_i = 1'b1;
      #3;
      chk("rst_valid", m_valid_o, 0);
      chk("rst_last", m_last_o, 0);
      chk("rst_keep", m_keep_o, 0);
      chk("rst_lane_ready", lane_ready_o, 0);
      chk("rst_err", err_o, 0);
      @(negedge clk_i);
      rst_i = 1'b0;
      @(posedge clk_i);
      #1;

      // Round-robin over lanes 0, 1 and 3, two single-beat packets each.
      for (int r = 0; r < 2; r++) begin
         push_pkt(0, 8);
         push_pkt(1, 8);
         push_pkt(3, 8);
      end
      grant_log.delete();
      drain(0, 0, -1, 0, hs, stalls, lk);
      chk("rr_count", grant_log.size(), 6);
      for (int i = 0; i < 6; i++)
         if (i < grant_log.size()) chk("rr_order", grant_log[i], rr_exp[i]);
      chk("rr_hs", hs, 6);

      for (int i = 0; i < 8; i++) begin
         push_pkt(vecs[i].lane, vecs[i].len);
         drain(0, 0, -1, 0, hs, stalls, lk);
         chk("tbl_beats", hs, vecs[i].beats);
         chk("tbl_keep", lk, vecs[i].keep);
      end

      // Backpressure: ready toggles every cycle on a 5-beat packet.
      push_pkt(2, 35);
      drain(2, 0, -1, 0, hs, stalls, lk);
      chk("bp_hs", hs, 5);
      chk("bp_keep", lk, 8'h07);

      // Lane underflow: lane 2 drops valid for 3 cycles while lane 1 waits.
      push_pkt(1, 8);
      drain(0, 0, -1, 0, hs, stalls, lk);
      push_pkt(2, 40);
      push_pkt(1, 8);
      grant_log.delete();
      drain(0, 0, 2, 2, hs, stalls, lk);
      chk("uf_stalls", stalls, 3);
      chk("uf_hs", hs, 6);
      chk("uf_count", grant_log.size(), 2);
      if (grant_log.size() == 2) begin
         chk("uf_first", grant_log[0], 2);
         chk("uf_second", grant_log[1], 1);
      end

      for (int r = 0; r < 8; r++) begin
         for (int l = 0; l < NL; l++) begin
            int np = $urandom_range(0, 3);
            for (int p = 0; p < np; p++) push_pkt(l, $urandom_range(0, 64));
         end
         drain(1, 1, -1, 0, hs, stalls, lk);
      end

      // Reset on beat 2 of a 4-beat packet on lane 1, after lane 0 was served last.
      push_pkt(0, 8);
      drain(0, 0, -1, 0, hs, stalls, lk);
      push_pkt(1, 32);
      m_ready_i = 1'b1;
      apply();
      cycle();
      chk("rst_arb_idle", s_valid, 0);
      cycle();
      chk("rst_beat1_hs", s_valid & s_mready, 1);
      chk("rst_beat1_lane", s_lready, 4'b0010);
      #1;
      chk("rst_beat2_valid", m_valid_o, 1);
      #1 rst_i = 1'b1;
      #1;
      chk("rst_async_valid", m_valid_o, 0);
      chk("rst_async_lane_ready", lane_ready_o, 0);
      chk("rst_async_last", m_last_o, 0);
      chk("rst_async_keep", m_keep_o, 0);
      for (int l = 0; l < NL; l++) lq[l].delete();
      last_lane = NL - 1;
      err_model = 1'b0;
      apply();
      @(negedge clk_i);
      rst_i = 1'b0;
      @(posedge clk_i);
      #1;
      chk("rst_err_clear", err_o, 0);
      push_pkt(2, 8);
      push_pkt(0, 8);
      grant_log.delete();
      drain(0, 0, -1, 0, hs, stalls, lk);
      chk("rst_grant_count", grant_log.size(), 2);
      if (grant_log.size() > 0) chk("rst_first_grant", grant_log[0], 0);

      // Oversize header length.
`ifdef PACKET_BUFFER_READ_LEN_CHECK_EN
      len_beats_exp = 200;
      err_exp       = 1'b1;
`else
      len_beats_exp = 250;
      err_exp       = 1'b0;
`endif
      push_pkt(0, 2000);
      drain(0, 0, -1, 0, hs, stalls, lk);
      chk("len_beats", hs, len_beats_exp);
      chk("len_keep", lk, 8'hFF);
      chk("len_err", err_o, err_exp);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
